fp_event_queue: RTL and testbench

Front-panel event controller between the rotary encoder decoder and the CPU register interface. It queues every encoder state-change event (click, direction, switch) in a small FIFO so the CPU can read them one at a time without losing back-to-back events. It also keeps a saturating signed detent count and raises an interrupt request while events are pending. Reading the event register pops one entry.

---
 rtl/fp_event_queue.sv | 120 ++++++++++++
 tb/tb_fp_event_queue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_event_queue.sv
// Front-panel encoder event FIFO with sticky overflow, saturating signed detent
// counter and a level interrupt while events are pending.
module fp_event_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_state_change_stb,
    input  logic             click,
    input  logic             clockwise,
    input  logic             switch,
    input  logic             rd_stb,
    input  logic             count_clr,
    output logic [7:0]       event_reg,
    output logic [CNT_W-1:0] detent_count,
    output logic             irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [2:0]        r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_count;
    logic              r_ovf;
    logic [7:0]        r_event;
    logic              r_irq;
    logic [CNT_W-1:0]  r_detent;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic              w_step;
    logic [2:0]        w_head;
    logic [2:0]        w_pending;
    logic [CNT_W-1:0]  w_det_max;
    logic [CNT_W-1:0]  w_det_min;

    assign w_full  = (r_count == PW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = rd_stb && !w_empty;
    // A full FIFO still accepts when the same cycle frees a slot.
    assign w_push  = enc_state_change_stb && (!w_full || rd_stb);
    assign w_drop  = enc_state_change_stb && w_full && !rd_stb;
    assign w_step  = enc_state_change_stb && click;

    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_pending = (32'(r_count) >= 32'd8) ? 3'd7 : 3'(32'(r_count) - 32'd1);
    assign w_det_max = {1'b0, {(CNT_W-1){1'b1}}};
    assign w_det_min = {1'b1, {(CNT_W-1){1'b0}}};

    // Entry storage has no reset; contents are only observed behind valid pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {switch, clockwise, click};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (rd_stb) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Presentation stage: snapshot of the queue state as of the previous edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_event <= 8'h00;
            r_irq   <= 1'b0;
        end else begin
            r_irq <= !w_empty;
            if (w_empty) begin
                r_event <= {3'b000, r_ovf, 4'b0000};
            end else begin
                r_event <= {w_pending, r_ovf, 1'b1, w_head};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_detent <= '0;
        end else if (count_clr) begin
            r_detent <= '0;
        end else if (w_step) begin
            if (clockwise && (r_detent != w_det_max)) begin
                r_detent <= r_detent + 1'b1;
            end else if (!clockwise && (r_detent != w_det_min)) begin
                r_detent <= r_detent - 1'b1;
            end
        end
    end

    assign event_reg    = r_event;
    assign irq          = r_irq;
    assign detent_count = r_detent;
endmodule

// File: tb/tb_fp_event_queue.sv
// Randomized and directed bench for fp_event_queue against a queue-based model;
// a second instance with a 4-bit counter exercises detent saturation.
module tb_fp_event_queue;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       stb = 1'b0;
    logic       click = 1'b0;
    logic       cw = 1'b0;
    logic       sw = 1'b0;
    logic       rd = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] ev8;
    logic [7:0] det8;
    logic       irq8;
    logic [7:0] ev4;
    logic [3:0] det4;
    logic       irq4;

    int checks = 0;
    int failures = 0;

    // Behavioural model
    logic [2:0] m_q[$];
    bit         m_ovf;
    int         m_det8;
    int         m_det4;

    always #5 clk = ~clk;

    fp_event_queue #(.DEPTH(8), .CNT_W(8)) u_dut8 (
        .clk(clk), .reset(reset), .enc_state_change_stb(stb), .click(click),
        .clockwise(cw), .switch(sw), .rd_stb(rd), .count_clr(clr),
        .event_reg(ev8), .detent_count(det8), .irq(irq8)
    );

    fp_event_queue #(.DEPTH(8), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .enc_state_change_stb(stb), .click(click),
        .clockwise(cw), .switch(sw), .rd_stb(rd), .count_clr(clr),
        .event_reg(ev4), .detent_count(det4), .irq(irq4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int sat_step(input int v, input bit up, input int w);
        int hi = (1 << (w - 1)) - 1;
        int lo = -(1 << (w - 1));
        if (up) return (v < hi) ? v + 1 : v;
        return (v > lo) ? v - 1 : v;
    endfunction

    function automatic logic [7:0] exp_event();
        int n = m_q.size();
        if (n == 0) return {3'b000, m_ovf, 4'b0000};
        return {3'((n - 1 > 7) ? 7 : n - 1), m_ovf, 1'b1, m_q[0]};
    endfunction

    task automatic model_update(input bit s, input bit c, input bit d, input bit w,
                                input bit r, input bit k);
        int  n = m_q.size();
        bit  acc = s && (n < 8 || r);
        bit  drop = s && !acc;
        if (r && n > 0) void'(m_q.pop_front());
        if (acc) m_q.push_back({w, d, c});
        if (drop) m_ovf = 1'b1;
        else if (r) m_ovf = 1'b0;
        if (k) begin
            m_det8 = 0;
            m_det4 = 0;
        end else if (s && c) begin
            m_det8 = sat_step(m_det8, d, 8);
            m_det4 = sat_step(m_det4, d, 4);
        end
    endtask

    // One clock of stimulus; consecutive calls give back-to-back cycles.
    task automatic drive(input bit s, input bit c, input bit d, input bit w,
                         input bit r, input bit k);
        stb = s; click = c; cw = d; sw = w; rd = r; clr = k;
        @(posedge clk);
        #1;
        stb = 0; click = 0; cw = 0; sw = 0; rd = 0; clr = 0;
        model_update(s, c, d, w, r, k);
    endtask

    task automatic settle_check(input string tag);
        @(posedge clk);
        #1;
        check({tag, ".ev"}, 32'(ev8), 32'(exp_event()));
        check({tag, ".irq"}, 32'(irq8), 32'(m_q.size() != 0));
        check({tag, ".det8"}, 32'(det8), 32'(m_det8) & 32'hFF);
        check({tag, ".det4"}, 32'(det4), 32'(m_det4) & 32'hF);
        $display("txn %s ev=%02h irq=%0d det8=%0d det4=%0d q=%0d", tag, ev8, irq8,
                 $signed(det8), $signed(det4), m_q.size());
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check({tag, ".rst_ev"}, 32'(ev8), 32'h00);
        check({tag, ".rst_irq"}, 32'(irq8), 32'h0);
        check({tag, ".rst_det"}, 32'(det8), 32'h00);
        m_q.delete();
        m_ovf = 1'b0;
        m_det8 = 0;
        m_det4 = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        settle_check({tag, ".post_rst"});
    endtask

    initial begin
        m_ovf = 1'b0;
        m_det8 = 0;
        m_det4 = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        settle_check("init");

        // Reset mid-queue with three entries
        for (int i = 0; i < 3; i++) drive(1, 1, 1, 0, 0, 0);
        settle_check("pre_rst");
        do_reset("midq");

        // Ordering
        drive(1, 1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 0);
        settle_check("ord");
        check("ord0", 32'(ev8), 32'h4B);
        drive(0, 0, 0, 0, 1, 0);
        settle_check("ord_p1");
        check("ord1", 32'(ev8), 32'h29);
        drive(0, 0, 0, 0, 1, 0);
        settle_check("ord_p2");
        check("ord2", 32'(ev8), 32'h0C);
        drive(0, 0, 0, 0, 1, 0);
        settle_check("ord_p3");
        check("ord_empty", 32'(ev8), 32'h00);
        check("ord_irq", 32'(irq8), 32'h0);
        check("ord_det", 32'(det8), 32'h00);

        // Overflow
        do_reset("ovf");
        for (int i = 0; i < 9; i++) drive(1, 1, 1, 0, 0, 0);
        settle_check("ovf_full");
        check("ovf_ev", 32'(ev8), 32'hFB);
        check("ovf_det", 32'(det8), 32'd9);
        drive(0, 0, 0, 0, 1, 0);
        settle_check("ovf_pop");
        check("ovf_clr", 32'(ev8), 32'hCB);

        // Simultaneous push and pop at full; new entry leaves last
        do_reset("pp");
        for (int i = 0; i < 8; i++) drive(1, 1, 1, 0, 0, 0);
        drive(1, 0, 0, 1, 1, 0);
        settle_check("pp_full");
        check("pp_ev", 32'(ev8), 32'hEB);
        for (int i = 0; i < 7; i++) drive(0, 0, 0, 0, 1, 0);
        settle_check("pp_last");
        check("pp_lastout", 32'(ev8), 32'h0C);

        // Push and pop on empty, then read-when-empty
        do_reset("pe");
        drive(1, 1, 1, 0, 1, 0);
        settle_check("pe_push");
        check("pe_ev", 32'(ev8), 32'h0B);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 0);
        settle_check("pe_underflow");
        check("pe_empty", 32'(ev8), 32'h00);
        drive(1, 1, 1, 0, 0, 0);
        settle_check("pe_again");
        check("pe_ev2", 32'(ev8), 32'h0B);

        // Saturation and clear priority
        do_reset("sat");
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 1, 0, 0, 0);
            drive(0, 0, 0, 0, 1, 0);
        end
        settle_check("sat");
        check("sat_det4", 32'(det4), 32'd7);
        check("sat_det8", 32'(det8), 32'd10);
        drive(1, 1, 0, 0, 0, 1);
        settle_check("clr");
        check("clr_det4", 32'(det4), 32'd0);
        check("clr_ev", 32'(ev8), 32'h09);

        // Randomized traffic with phases of heavy and light reads
        do_reset("rnd");
        for (int i = 0; i < 400; i++) begin
            int rd_pct = ((i / 50) % 2 == 0) ? 15 : 60;
            bit s = ($urandom_range(0, 99) < 65);
            bit c = ($urandom_range(0, 99) < 70);
            bit d = $urandom_range(0, 1) != 0;
            bit w = $urandom_range(0, 1) != 0;
            bit r = ($urandom_range(0, 99) < rd_pct);
            bit k = ($urandom_range(0, 99) < 3);
            drive(s, c, d, w, r, k);
            if ($urandom_range(0, 3) != 0) settle_check($sformatf("rnd%0d", i));
        end
        settle_check("rnd_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
